// File: rtl/mem_responder.sv
// Single-port word RAM responder for the multicycle core's mem_read/mem_write/mem_resp
// handshake. Serves one request at a time with a fixed latency, applies byte-lane
// write enables, and keeps completed read/write counters.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 3   // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    is_write_q;
  logic                    resp_q;
  logic [31:0]             rdata_q;
  logic [31:0]             rd_cnt_q;
  logic [31:0]             wr_cnt_q;
  logic [31:0]             ram_q [Depth];

  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    req_any;
  logic                    unused_addr;

  // Out-of-range addresses alias by dropping the upper word-index bits.
  assign req_idx     = mem_address[ADDR_WIDTH+1:2];
  assign req_any     = mem_read | mem_write;
  assign unused_addr = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

  // Request FSM with registered outputs; read data is captured on entry to StResp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      is_write_q <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
      rd_cnt_q   <= 32'd0;
      wr_cnt_q   <= 32'd0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            idx_q      <= req_idx;
            wdata_q    <= mem_wdata;
            be_q       <= mem_byte_enable;
            is_write_q <= mem_write;  // write wins when both are high
            cnt_q      <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q <= StResp;
              resp_q  <= 1'b1;
              if (!mem_write) begin
                rdata_q <= ram_q[req_idx];
              end
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (!req_any) begin
            // Initiator withdrew the request: drop it silently.
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= StResp;
            cnt_q   <= 4'd0;
            resp_q  <= 1'b1;
            if (!is_write_q) begin
              rdata_q <= ram_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (is_write_q) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
          end else begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write commit at the edge closing StResp; an async reset leaves StResp, discarding it.
  always_ff @(posedge clk) begin
    if (state_q == StResp && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          ram_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata   = rdata_q;
  assign mem_resp    = resp_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a reference RAM model feeds a queue of expected
// read data that is popped at each mem_resp. Extra instances check LATENCY=1 and 15
// back-to-back pulse spacing.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [31:0] read_count;
  logic [31:0] write_count;

  logic        rst_b;
  logic        rd_b;
  logic [31:0] rdata1, rc1, wc1, rdata15, rc15, wc15;
  logic        resp1, resp15;

  int          checks;
  int          passes;
  int          fails;
  logic [31:0] model [1024];
  logic [31:0] exp_q [$];
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;
  logic [31:0] last_rdata;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .read_count      (read_count),
    .write_count     (write_count)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
    .clk             (clk),
    .rst             (rst_b),
    .mem_read        (rd_b),
    .mem_write       (1'b0),
    .mem_address     (32'd0),
    .mem_wdata       (32'd0),
    .mem_byte_enable (4'd0),
    .mem_rdata       (rdata1),
    .mem_resp        (resp1),
    .read_count      (rc1),
    .write_count     (wc1)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) dut_l15 (
    .clk             (clk),
    .rst             (rst_b),
    .mem_read        (rd_b),
    .mem_write       (1'b0),
    .mem_address     (32'd0),
    .mem_wdata       (32'd0),
    .mem_byte_enable (4'd0),
    .mem_rdata       (rdata15),
    .mem_resp        (resp15),
    .read_count      (rc15),
    .write_count     (wc15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle, wait for its response, then release it.
  task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit perturb);
    int          n;
    logic [31:0] got;
    mem_write       = w;
    mem_read        = r;
    mem_address     = a;
    mem_wdata       = d;
    mem_byte_enable = b;
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
      end
      exp_wr++;
    end else begin
      exp_q.push_back(model[a[11:2]]);
      exp_rd++;
    end
    step();
    if (perturb) begin
      mem_address     = a ^ 32'h0000_0FFC;
      mem_wdata       = ~d;
      mem_byte_enable = ~b;
    end
    n = 1;
    while (mem_resp !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd3);
    if (!w) begin
      got = exp_q.pop_front();
      chk("rdata", mem_rdata, got);
      last_rdata = got;
    end else begin
      chk("rdata_hold", mem_rdata, last_rdata);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
    chk("resp_width", 32'(mem_resp), 32'd0);
    chk("read_count", read_count, exp_rd);
    chk("write_count", write_count, exp_wr);
  endtask

  initial begin
    int first1, prev1, cnt1, first15, prev15, cnt15;
    checks = 0; passes = 0; fails = 0;
    exp_rd = 0; exp_wr = 0; last_rdata = 0;
    rst = 1'b0; rst_b = 1'b0; rd_b = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 32'd0; mem_wdata = 32'd0; mem_byte_enable = 4'd0;

    repeat (3) step();
    chk("rst_resp", 32'(mem_resp), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_rcount", read_count, 32'd0);
    chk("rst_wcount", write_count, 32'd0);
    rst = 1'b1;
    step();

    // Basic write then read.
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);

    // Byte-lane writes, including an empty mask.
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h1122_3344, 4'hF, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0000_AB00, 4'b0010, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);

    // Abort during BUSY.
    do_req(1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 4'hF, 1'b0);
    mem_write = 1'b1; mem_address = 32'h0000_0080;
    mem_wdata = 32'hFFFF_FFFF; mem_byte_enable = 4'hF;
    step();
    chk("abort_busy_resp", 32'(mem_resp), 32'd0);
    mem_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_resp", 32'(mem_resp), 32'd0);
    end
    chk("abort_wcount", write_count, exp_wr);
    do_req(1'b0, 1'b1, 32'h0000_0080, 32'h0, 4'h0, 1'b0);

    // Address aliasing past RAM depth.
    do_req(1'b1, 1'b0, 32'h0000_1004, 32'h5A5A_5A5A, 4'hF, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0004, 32'h0, 4'h0, 1'b0);

    // Simultaneous read+write acts as a write.
    do_req(1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_000C, 32'h0, 4'h0, 1'b0);

    // Inputs changed during BUSY are ignored.
    do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0BAD_F00D, 4'hF, 1'b1);
    do_req(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1);

    // Reset during BUSY of a write.
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    mem_write = 1'b1; mem_address = 32'h0000_0020;
    mem_wdata = 32'h1234_5678; mem_byte_enable = 4'hF;
    step();
    rst = 1'b0;
    #1;
    exp_rd = 0; exp_wr = 0; last_rdata = 0;
    chk("mid_rst_resp", 32'(mem_resp), 32'd0);
    chk("mid_rst_rdata", mem_rdata, 32'd0);
    chk("mid_rst_rcount", read_count, 32'd0);
    chk("mid_rst_wcount", write_count, 32'd0);
    mem_write = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_req(1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h0, 1'b0);

    // Back-to-back reads held high on LATENCY=1 and LATENCY=15 builds.
    first1 = -1; prev1 = -1; cnt1 = 0;
    first15 = -1; prev15 = -1; cnt15 = 0;
    rst_b = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (resp1 === 1'b1) begin
        if (prev1 < 0) chk("l1_first", 32'(c), 32'd1);
        else chk("l1_period", 32'(c - prev1), 32'd2);
        prev1 = c;
        cnt1++;
      end
      if (resp15 === 1'b1) begin
        if (prev15 < 0) chk("l15_first", 32'(c), 32'd15);
        else chk("l15_period", 32'(c - prev15), 32'd16);
        prev15 = c;
        cnt15++;
      end
    end
    chk("l1_pulses", 32'(cnt1), 32'd32);
    chk("l1_reads", rc1, 32'd32);
    chk("l15_pulses", 32'(cnt15), 32'd4);
    chk("l15_reads", rc15, 32'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port memory responder for the multicycle RV32I core: the target end of the core's `mem_read`/`mem_write`/`mem_resp` handshake. It holds a word-addressed RAM and accepts one request at a time. It completes each request after a fixed, parameterized latency and applies per-byte write enables supplied by the core's control unit. It replaces the testbench memory model in integration simulations and keeps read/write counters for the verification bench.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 3: cycles from acceptance to `mem_resp`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  read request; held by the initiator until `mem_resp`.
- `mem_write`  in  1  write request; held by the initiator until `mem_resp`.
- `mem_address`  in  32  byte address; bits [1:0] ignored; word index = `mem_address[ADDR_WIDTH+1:2]`.
- `mem_wdata`  in  32  write data, already shifted into byte lanes by the initiator.
- `mem_byte_enable`  in  4  write lane mask; bit i enables `mem_wdata[8i+7:8i]`.
- `mem_rdata`  out  32  read word; valid in the `mem_resp` cycle of a read.
- `mem_resp`  out  1  one-cycle completion pulse.
- `read_count`  out  32  completed reads since reset.
- `write_count`  out  32  completed writes since reset.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: the block samples requests.
  - If `mem_write` or `mem_read` is high, latch the request:
    - word index, `mem_wdata`, and `mem_byte_enable`
    - type: write if `mem_write`=1, else read
  - Load the latency counter with LATENCY-1.
  - If LATENCY=1, go to RESP; otherwise go to BUSY.
- BUSY: decrement the counter each cycle. Go to RESP on the edge where the counter reaches 0.
- RESP:
  - `mem_resp`=1.
  - Reads: `mem_rdata` = RAM[latched index] for this cycle.
  - The edge ending RESP commits the write, increments the matching counter, and returns to IDLE.
- Writes update only enabled lanes. `mem_byte_enable`=0000 still completes and counts, but leaves the RAM unchanged.
- Simultaneous `mem_read` and `mem_write` is treated as a write; only `write_count` increments.
- Request inputs are sampled only at acceptance. Later changes to address, data, or mask during BUSY are ignored.
- Abort: if both `mem_read` and `mem_write` are low during BUSY, return to IDLE on the next edge with no commit, no `mem_resp`, and no count.
- Requests still asserted in the cycle after RESP are accepted as a new request. The core changes state on `mem_resp`, so back-to-back requests see one IDLE cycle between them.
- `mem_rdata` holds its last read value until the next read's RESP cycle. Writes never change it.
- RAM contents are not reset. Read-before-write returns X in simulation.
- Counters wrap modulo 2^32.
- Addresses beyond the RAM depth alias via truncation of the word index.

## Timing
- Reset values: state IDLE, `mem_resp`=0, `mem_rdata`=0, `read_count`=0, `write_count`=0, latency counter 0.
- Reset asserted mid-request:
  - Outputs go to reset values immediately.
  - The pending write is discarded.
  - After reset deasserts, the first edge with a request asserted is an acceptance.
- Latency: a request is accepted at the edge closing IDLE cycle t; `mem_resp` is high during cycle t+LATENCY only.
- Write data becomes visible to a read accepted at the earliest legal time, which is the IDLE cycle after RESP.
- Throughput: one request per LATENCY+1 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Write 0xDEADBEEF to 0x00000040 with mask 1111, then read 0x00000040 → `mem_resp` pulses 3 cycles after each acceptance; `mem_rdata`=0xDEADBEEF; `write_count`=1, `read_count`=1.
- From word 0x11223344 at 0x40, write 0x0000AB00 with mask 0010, then read → 0x1122AB44. Repeat with mask 0000 → value unchanged, `write_count` incremented.
- Abort: raise `mem_write` (data 0xFFFFFFFF to 0x80, prior content 0), drop it after 1 cycle of BUSY, then read 0x80 → 0x00000000; no `mem_resp` for the aborted write; `write_count` unchanged.
- Address alias with ADDR_WIDTH=10: write 0x5A5A5A5A to 0x00001004, then read 0x00000004 → 0x5A5A5A5A.
- Assert `rst` low during BUSY of a write to 0x20 (prior content 0x0) → `mem_resp`=0 and counters=0 immediately; a subsequent read of 0x20 returns 0x0.
- Run LATENCY=1 and LATENCY=15 builds with back-to-back reads held continuously high → `mem_resp` pulses exactly every 2 and 16 cycles, each one cycle wide.
